conv_pool_sequencer: RTL
========================

CONV_POOL_SEQUENCER -- requirements
Module: conv_pool_sequencer

Interface
REQ-001 Parameter DIM, default 14: input feature-map width and height in pixels.
REQ-002 Parameter K, default 5: conv kernel size; valid-only windows, no padding, stride 1.
REQ-003 Parameter CONV_LAT, default 2: fixed cycle latency from conv_en to the matching conv output; must be at least 1.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin a frame.
REQ-007 in_valid  in  1  upstream pixel present.
REQ-008 in_ready  out  1  sequencer accepts a pixel this cycle.
REQ-009 conv_en  out  1  clock enable for the conv block; replaces the gated clock.
REQ-010 conv_out_valid  out  1  conv output at the current cycle is a valid window.
REQ-011 pool_en  out  1  clock enable for max_pool.
REQ-012 pool_out_valid  out  1  max_pool output holds a completed 2x2 result.
REQ-013 out_row, out_col  out  $clog2(ODIM/2) each  pooled coordinates qualified by pool_out_valid.
REQ-014 frame_done  out  1  one-cycle pulse at frame end.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 ODIM SHALL equal DIM-K+1; elaboration SHALL fail if ODIM is odd or K>DIM.
REQ-017 FSM states SHALL be IDLE, STREAM, DRAIN, DONE.
REQ-018 IDLE to STREAM SHALL occur on start; in_ready SHALL be 0 in IDLE, so a pixel offered with start is not accepted.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 A pixel is accepted when in_valid and in_ready; in_ready SHALL be 1 only in STREAM.
REQ-021 Input counters in_row and in_col SHALL advance only on accept; in_col wraps at DIM-1 and increments in_row.
REQ-022 conv_en SHALL equal accept, combinationally.
REQ-023 A raw window flag SHALL be accept AND in_row>=K-1 AND in_col>=K-1.
REQ-024 The raw window flag SHALL pass through a CONV_LAT-stage shift register; its output SHALL drive conv_out_valid.
REQ-025 pool_en SHALL equal conv_out_valid.
REQ-026 Conv-map counters cr and cc SHALL advance on conv_out_valid and wrap at ODIM-1.
REQ-027 pool_out_valid SHALL be registered, asserted the cycle after a conv_out_valid with cr and cc both odd.
REQ-028 out_row and out_col SHALL be cr>>1 and cc>>1, registered with pool_out_valid.
REQ-029 STREAM to DRAIN SHALL occur in the cycle after the DIM*DIM-th accept.
REQ-030 DRAIN SHALL last exactly CONV_LAT+1 cycles, then go to DONE.
REQ-031 DONE SHALL last one cycle, with frame_done=1, then return to IDLE.
REQ-032 In IDLE, all counters SHALL be 0; in_valid bubbles SHALL stall counters without loss or duplication.
REQ-033 Exactly ODIM*ODIM conv_out_valid pulses and (ODIM/2)^2 pool_out_valid pulses SHALL occur per frame, in raster order.

Reset
REQ-034 Reset SHALL force state to IDLE.
REQ-035 Reset SHALL clear all counters, the shift register, and registered outputs.
REQ-036 Every output SHALL be 0 during and after reset until the next start, including when reset is asserted mid-frame; no stale valid SHALL emerge afterwards.

Structure
REQ-037 FSM state encoding and ODIM/pool-dim constants SHALL live in the shared cnn package.
REQ-038 The CONV_LAT valid delay line SHALL be one sub-module, valid_delay, parameterized by depth.

Verification
REQ-039 Defaults, start at cycle 0, in_valid held 1: accepts in cycles 1..196; first pool_out_valid at cycle 79 (0,0); last at cycle 199 (4,4); frame_done at cycle 200; busy low at 201.
REQ-040 Same frame with in_valid toggling every cycle: 100 conv_out_valid, 25 pool_out_valid, coordinates in raster order, exactly one frame_done.
REQ-041 start pulsed at cycles 50 and 150 during STREAM: no effect; single frame_done.
REQ-042 reset asserted at cycle 100 for 2 cycles: all outputs 0 immediately; no pool_out_valid afterwards; a new start yields a full correct frame.
REQ-043 Back-to-back frames with start in the cycle after frame_done: second frame identical to the first, shifted by the restart offset.
REQ-044 DIM=8, K=3, CONV_LAT=1: 36 conv_out_valid, 9 pool_out_valid, last at (2,2).

Source files
------------

// File: rtl/conv_pool_sequencer_pkg.sv
// Shared definitions for the conv/pool sequencer.
// Holds the sequencer state encoding and the helpers that derive the conv-map
// and pooled-map dimensions (plus counter widths) from the frame parameters.
package conv_pool_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDrain  = 2'd2,
        StDone   = 2'd3
    } state_e;

    // Conv-map edge length for valid-only, stride-1 windows.
    function automatic int unsigned calc_odim(input int unsigned dim, input int unsigned k);
        return dim - k + 1;
    endfunction

    // Pooled-map edge length (2x2 pooling of the conv map).
    function automatic int unsigned calc_pdim(input int unsigned dim, input int unsigned k);
        return calc_odim(dim, k) / 2;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned bit_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_pool_sequencer_valid_delay.sv
// valid_delay: fixed-depth shift register for a single valid bit.
// Ports:
//   clk_i    - clock, rising edge
//   reset_i  - asynchronous active-high reset, clears every stage
//   valid_i  - valid bit entering the line
//   valid_o  - valid bit delayed by Depth cycles
module valid_delay #(
    parameter int unsigned Depth = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic valid_i,
    output logic valid_o
);

    logic [Depth-1:0] shift_q, shift_d;

    always_comb begin
        shift_d    = shift_q;
        shift_d[0] = valid_i;
        for (int unsigned i = 1; i < Depth; i++) begin
            shift_d[i] = shift_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign valid_o = shift_q[Depth-1];

endmodule

// File: rtl/conv_pool_sequencer.sv
// conv_pool_sequencer: frame sequencer for a conv block followed by 2x2 max pooling.
// Accepts DIM*DIM raster pixels, flags which accepted pixels complete a KxK window,
// delays that flag by the conv latency, tracks conv-map position and reports pooled
// coordinates, then drains the conv pipeline and pulses frame_done.
// Ports:
//   clk_i, reset_i         - clock, asynchronous active-high reset
//   start_i                - one-cycle frame request (honoured only when idle)
//   in_valid_i/in_ready_o  - upstream pixel handshake
//   conv_en_o              - conv clock enable (pixel accepted this cycle)
//   conv_out_valid_o       - conv output is a valid window
//   pool_en_o              - max_pool clock enable
//   pool_out_valid_o       - pooled result ready at out_row_o/out_col_o
//   frame_done_o           - one-cycle end-of-frame pulse
//   busy_o                 - sequencer not idle
module conv_pool_sequencer
    import conv_pool_sequencer_pkg::*;
#(
    parameter int unsigned DIM      = 14,
    parameter int unsigned K        = 5,
    parameter int unsigned CONV_LAT = 2
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic                                       start_i,
    input  logic                                       in_valid_i,
    output logic                                       in_ready_o,
    output logic                                       conv_en_o,
    output logic                                       conv_out_valid_o,
    output logic                                       pool_en_o,
    output logic                                       pool_out_valid_o,
    output logic [bit_width(calc_pdim(DIM, K))-1:0]    out_row_o,
    output logic [bit_width(calc_pdim(DIM, K))-1:0]    out_col_o,
    output logic                                       frame_done_o,
    output logic                                       busy_o
);

    localparam int unsigned ODIM = calc_odim(DIM, K);
    localparam int unsigned InW  = bit_width(DIM);
    localparam int unsigned CntW = bit_width(ODIM);
    localparam int unsigned OutW = bit_width(calc_pdim(DIM, K));
    localparam int unsigned DrnW = bit_width(CONV_LAT + 1);

    if (K > DIM || (ODIM % 2) != 0 || CONV_LAT < 1) begin : g_bad_cfg
        $error("conv_pool_sequencer: need K<=DIM, even DIM-K+1 and CONV_LAT>=1");
    end

    state_e            state_q, state_d;
    logic [InW-1:0]    in_row_q, in_row_d, in_col_q, in_col_d;
    logic [CntW-1:0]   cr_q, cr_d, cc_q, cc_d;
    logic [DrnW-1:0]   drain_q, drain_d;
    logic              pool_valid_q, pool_valid_d;
    logic [OutW-1:0]   out_row_q, out_row_d, out_col_q, out_col_d;
    logic              accept, last_px, raw_win, conv_valid;

    assign in_ready_o = (state_q == StStream);
    assign accept     = in_ready_o & in_valid_i;
    assign last_px    = accept && (in_row_q == InW'(DIM - 1)) && (in_col_q == InW'(DIM - 1));
    // Pixel closes a KxK window once both coordinates reach the kernel's far edge.
    assign raw_win    = accept && (in_row_q >= InW'(K - 1)) && (in_col_q >= InW'(K - 1));

    valid_delay #(
        .Depth(CONV_LAT)
    ) u_valid_delay (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .valid_i(raw_win),
        .valid_o(conv_valid)
    );

    // FSM next state
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                drain_d = '0;
                if (start_i) state_d = StStream;
            end
            StStream: begin
                drain_d = '0;
                if (last_px) state_d = StDrain;
            end
            StDrain: begin
                // Cover the conv latency plus the registered pool stage.
                if (drain_q == DrnW'(CONV_LAT)) begin
                    drain_d = '0;
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + DrnW'(1);
                end
            end
            StDone: begin
                drain_d = '0;
                state_d = StIdle;
            end
            default: begin
                drain_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Input and conv-map raster counters
    always_comb begin
        in_row_d = in_row_q;
        in_col_d = in_col_q;
        cr_d     = cr_q;
        cc_d     = cc_q;
        if (accept) begin
            if (in_col_q == InW'(DIM - 1)) begin
                in_col_d = '0;
                in_row_d = (in_row_q == InW'(DIM - 1)) ? '0 : in_row_q + InW'(1);
            end else begin
                in_col_d = in_col_q + InW'(1);
            end
        end
        if (conv_valid) begin
            if (cc_q == CntW'(ODIM - 1)) begin
                cc_d = '0;
                cr_d = (cr_q == CntW'(ODIM - 1)) ? '0 : cr_q + CntW'(1);
            end else begin
                cc_d = cc_q + CntW'(1);
            end
        end
    end

    // A 2x2 pool block completes on its bottom-right conv output (odd row, odd col).
    always_comb begin
        pool_valid_d = conv_valid & cr_q[0] & cc_q[0];
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        if (pool_valid_d) begin
            out_row_d = OutW'(cr_q >> 1);
            out_col_d = OutW'(cc_q >> 1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            drain_q      <= '0;
            in_row_q     <= '0;
            in_col_q     <= '0;
            cr_q         <= '0;
            cc_q         <= '0;
            pool_valid_q <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            in_row_q     <= in_row_d;
            in_col_q     <= in_col_d;
            cr_q         <= cr_d;
            cc_q         <= cc_d;
            pool_valid_q <= pool_valid_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
        end
    end

    assign conv_en_o        = accept;
    assign conv_out_valid_o = conv_valid;
    assign pool_en_o        = conv_valid;
    assign pool_out_valid_o = pool_valid_q;
    assign out_row_o        = out_row_q;
    assign out_col_o        = out_col_q;
    assign frame_done_o     = (state_q == StDone);
    assign busy_o           = (state_q != StIdle);

endmodule
